// File: rtl/ldst_unit.sv
// ldst_unit: load/store stage of Buraq-Mini-RV32IM, between execute and write-back.
// Optional macro LDST_MISALIGN_TRAP_EN: suppress misaligned half/word accesses and pulse ldst_misaligned.
module ldst_unit #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    brq_clk,
  input  logic                    brq_rst,
  input  logic                    ieu_mem_ren,
  input  logic                    ieu_mem_wen,
  input  logic                    ieu_memtoreg,
  input  logic                    ieu_regfile_en,
  input  logic [2:0]              ieu_func3,
  input  logic [RegAddrWidth-1:0] ieu_addr_dst,
  input  logic [DataWidth-1:0]    ieu_mem_addr,
  input  logic [DataWidth-1:0]    ieu_store_data,
  input  logic [DataWidth-1:0]    ieu_alu_result_dealy,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [DataWidth-1:0]    dmem_rdata,
  output logic                    ldst_req,
  output logic                    ldst_we,
  output logic [DataWidth-1:0]    ldst_addr,
  output logic [3:0]              ldst_be,
  output logic [DataWidth-1:0]    ldst_wdata,
  output logic                    ldst_stall,
  output logic                    ldst_regfile_en,
  output logic                    ldst_memtoreg,
  output logic [RegAddrWidth-1:0] ldst_addr_dst,
  output logic [DataWidth-1:0]    ldst_mem_result,
  output logic [DataWidth-1:0]    ldst_alu_result,
  output logic                    ldst_misaligned
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic                    done_q, done_d;
  logic                    mem_access, misaligned, issue, pass_thru, load_done;
  logic [1:0]              off_q;
  logic [2:0]              func3_q;
  logic [RegAddrWidth-1:0] rd_q, addr_dst_q;
  logic                    rf_en_q, memtoreg_q, we_q;
  logic [DataWidth-1:0]    addr_q, wdata_q, mem_result_q, alu_result_q;
  logic [3:0]              be_q;
  logic                    regfile_en_q, memtoreg_out_q;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] mask;
    case (size)
      2'b00:   mask = 8'h01 << off;
      2'b01:   mask = 8'h03 << off;
      default: mask = 8'h0F;
    endcase
    return mask[3:0];
  endfunction

  function automatic logic [DataWidth-1:0] store_lanes(input logic [1:0] size,
                                                       input logic [DataWidth-1:0] d);
    case (size)
      2'b00:   return {(DataWidth/8){d[7:0]}};
      2'b01:   return {(DataWidth/16){d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Bytes shifted in past the top lane are zero, so misaligned loads read 0 there.
  function automatic logic [DataWidth-1:0] load_format(input logic [DataWidth-1:0] rdata,
                                                       input logic [1:0] off,
                                                       input logic [2:0] f3);
    logic [DataWidth-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(DataWidth-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(DataWidth-16){sh[15]}}, sh[15:0]};
      3'b100:  return {{(DataWidth-8){1'b0}}, sh[7:0]};
      3'b101:  return {{(DataWidth-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign mem_access = ieu_mem_ren | ieu_mem_wen;
`ifdef LDST_MISALIGN_TRAP_EN
  assign misaligned = ((ieu_func3[1:0] == 2'b01) & ieu_mem_addr[0]) |
                      ((ieu_func3[1:0] == 2'b10) & (ieu_mem_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif
  assign issue     = (state_q == IDLE) & mem_access & ~done_q & ~misaligned;
  assign pass_thru = (state_q == IDLE) & ~mem_access;
  assign load_done = (state_q == WAIT) & dmem_rvalid;

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (issue) state_d = REQ;
      REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? IDLE : WAIT;
          done_d  = we_q;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done_q marks the held instruction as finished so it is not issued twice.
  always_comb begin
    ldst_req   = (state_q == REQ);
    ldst_stall = (state_q != IDLE) | (mem_access & ~done_q & ~misaligned);
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      off_q          <= '0;
      func3_q        <= '0;
      rd_q           <= '0;
      rf_en_q        <= 1'b0;
      memtoreg_q     <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      regfile_en_q   <= 1'b0;
      memtoreg_out_q <= 1'b0;
      addr_dst_q     <= '0;
      mem_result_q   <= '0;
      alu_result_q   <= '0;
    end else begin
      if (issue) begin
        off_q      <= ieu_mem_addr[1:0];
        func3_q    <= ieu_func3;
        rd_q       <= ieu_addr_dst;
        rf_en_q    <= ieu_regfile_en;
        memtoreg_q <= ieu_memtoreg;
        we_q       <= ieu_mem_wen;
        addr_q     <= {ieu_mem_addr[DataWidth-1:2], 2'b00};
        be_q       <= byte_en(ieu_func3[1:0], ieu_mem_addr[1:0]);
        wdata_q    <= store_lanes(ieu_func3[1:0], ieu_store_data);
      end
      regfile_en_q <= (pass_thru & ieu_regfile_en) | (load_done & rf_en_q);
      if (pass_thru) begin
        addr_dst_q     <= ieu_addr_dst;
        memtoreg_out_q <= ieu_memtoreg;
        alu_result_q   <= ieu_alu_result_dealy;
      end
      if (load_done) begin
        mem_result_q   <= load_format(dmem_rdata, off_q, func3_q);
        addr_dst_q     <= rd_q;
        memtoreg_out_q <= memtoreg_q;
      end
    end
  end

`ifdef LDST_MISALIGN_TRAP_EN
  logic misaligned_q;
  always_ff @(posedge brq_clk) begin
    if (brq_rst) misaligned_q <= 1'b0;
    else         misaligned_q <= (state_q == IDLE) & mem_access & ~done_q & misaligned;
  end
  assign ldst_misaligned = misaligned_q;
`else
  assign ldst_misaligned = 1'b0;
`endif

  assign ldst_we         = we_q;
  assign ldst_addr       = addr_q;
  assign ldst_be         = be_q;
  assign ldst_wdata      = wdata_q;
  assign ldst_regfile_en = regfile_en_q;
  assign ldst_memtoreg   = memtoreg_out_q;
  assign ldst_addr_dst   = addr_dst_q;
  assign ldst_mem_result = mem_result_q;
  assign ldst_alu_result = alu_result_q;
endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: directed instructions, a byte-lane reference model and a memory responder.
module tb_ldst_unit;
`ifdef LDST_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        brq_clk, brq_rst;
  logic        ieu_mem_ren, ieu_mem_wen, ieu_memtoreg, ieu_regfile_en;
  logic [2:0]  ieu_func3;
  logic [4:0]  ieu_addr_dst;
  logic [31:0] ieu_mem_addr, ieu_store_data, ieu_alu_result_dealy;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        ldst_req, ldst_we, ldst_stall, ldst_regfile_en, ldst_memtoreg, ldst_misaligned;
  logic [31:0] ldst_addr, ldst_wdata, ldst_mem_result, ldst_alu_result;
  logic [3:0]  ldst_be;
  logic [4:0]  ldst_addr_dst;

  ldst_unit #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .ieu_mem_ren(ieu_mem_ren), .ieu_mem_wen(ieu_mem_wen), .ieu_memtoreg(ieu_memtoreg),
    .ieu_regfile_en(ieu_regfile_en), .ieu_func3(ieu_func3), .ieu_addr_dst(ieu_addr_dst),
    .ieu_mem_addr(ieu_mem_addr), .ieu_store_data(ieu_store_data),
    .ieu_alu_result_dealy(ieu_alu_result_dealy),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ldst_req(ldst_req), .ldst_we(ldst_we), .ldst_addr(ldst_addr), .ldst_be(ldst_be),
    .ldst_wdata(ldst_wdata), .ldst_stall(ldst_stall), .ldst_regfile_en(ldst_regfile_en),
    .ldst_memtoreg(ldst_memtoreg), .ldst_addr_dst(ldst_addr_dst),
    .ldst_mem_result(ldst_mem_result), .ldst_alu_result(ldst_alu_result),
    .ldst_misaligned(ldst_misaligned)
  );

  initial begin
    brq_clk = 1'b0;
    forever #5 brq_clk = ~brq_clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        m2r;
    logic        is_load;
    logic [31:0] data;
  } wb_t;
  wb_t wbq[$];

  logic [31:0] exp_addr, exp_wdata, lr_addr, lr_wdata, mem_word;
  logic [3:0]  exp_be, lr_be;
  logic        exp_we;
  int          req_cycles = 0;
  int          wb_pulses = 0;
  int          gnt_wait = 0;
  int          rv_wait = 0;

  assign dmem_rdata = mem_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    int n, off;
    logic [3:0] r;
    n   = size_bytes(f3);
    off = (n == 4) ? 0 : int'(a);
    r   = 4'b0000;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    logic [31:0] r;
    n = size_bytes(f3);
    r = 32'd0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] f3);
    int n, off;
    logic [7:0]  byts [4];
    logic [31:0] r;
    logic        fill;
    n   = size_bytes(f3);
    off = int'(a);
    for (int i = 0; i < 4; i++) byts[i] = (off + i < 4) ? w[8*(off+i) +: 8] : 8'h00;
    fill = (n < 4) && !f3[2] && byts[n-1][7];
    r = {32{fill}};
    for (int i = 0; i < n; i++) r[8*i +: 8] = byts[i];
    return r;
  endfunction

  // Memory responder: grants after gnt_wait REQ cycles, returns load data rv_wait cycles later.
  initial begin
    logic pend, gwe;
    int   rq_cnt, rv_cnt;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    pend = 1'b0; gwe = 1'b0; rq_cnt = 0; rv_cnt = 0;
    forever begin
      @(negedge brq_clk);
      if (dmem_rvalid) begin dmem_rvalid = 1'b0; pend = 1'b0; end
      if (dmem_gnt) begin
        dmem_gnt = 1'b0;
        if (!gwe) begin pend = 1'b1; rv_cnt = 0; end
      end
      if (pend) begin
        if (rv_cnt == rv_wait) dmem_rvalid = 1'b1;
        rv_cnt++;
      end else if (!brq_rst && ldst_req) begin
        if (rq_cnt == gnt_wait) begin dmem_gnt = 1'b1; gwe = ldst_we; rq_cnt = 0; end
        else rq_cnt++;
      end else rq_cnt = 0;
    end
  end

  initial begin
    wb_t e;
    forever begin
      @(negedge brq_clk);
      if (!brq_rst) begin
        if (ldst_req) begin
          req_cycles++;
          lr_addr = ldst_addr; lr_be = ldst_be; lr_wdata = ldst_wdata;
          chk("req_addr", ldst_addr, exp_addr);
          chk("req_be", 32'(ldst_be), 32'(exp_be));
          chk("req_wdata", ldst_wdata, exp_wdata);
          chk("req_we", 32'(ldst_we), 32'(exp_we));
        end
        if (ldst_regfile_en) begin
          wb_pulses++;
          if (wbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected rd=%0d got a write-back, expected none", ldst_addr_dst);
          end else begin
            e = wbq.pop_front();
            chk("wb_rd", 32'(ldst_addr_dst), 32'(e.rd));
            chk("wb_memtoreg", 32'(ldst_memtoreg), 32'(e.m2r));
            if (e.is_load) chk("wb_mem_result", ldst_mem_result, e.data);
            else           chk("wb_alu_result", ldst_alu_result, e.data);
          end
        end
      end
    end
  end

  task automatic run_instr(input logic ren, input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] alu, input logic [4:0] rd, input logic rfen,
                           input logic m2r, input logic [31:0] rdata, input int gw,
                           input int rw, output int stalls);
    logic misal;
    wb_t  e;
    @(posedge brq_clk); #1;
    ieu_mem_ren = ren; ieu_mem_wen = wen; ieu_func3 = f3; ieu_mem_addr = addr;
    ieu_store_data = sdata; ieu_alu_result_dealy = alu; ieu_addr_dst = rd;
    ieu_regfile_en = rfen; ieu_memtoreg = m2r;
    mem_word = rdata; gnt_wait = gw; rv_wait = rw;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = m_be(f3, addr[1:0]);
    exp_wdata = m_wdata(f3, sdata);
    exp_we    = wen;
    misal = TRAP && (ren || wen) &&
            ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
    e.rd = rd; e.m2r = m2r;
    if (!misal && rfen && !ren && !wen) begin
      e.is_load = 1'b0; e.data = alu; wbq.push_back(e);
    end else if (!misal && rfen && ren && !wen) begin
      e.is_load = 1'b1; e.data = m_load(rdata, addr[1:0], f3); wbq.push_back(e);
    end
    stalls = 0;
    forever begin
      @(negedge brq_clk);
      if (!ldst_stall) break;
      stalls++;
      if (stalls > 60) begin
        checks++; errors++;
        $display("FAIL stall_timeout stalled %0d cycles, expected completion", stalls);
        break;
      end
    end
  endtask

  task automatic bubble();
    @(posedge brq_clk); #1;
    ieu_mem_ren = 1'b0; ieu_mem_wen = 1'b0; ieu_regfile_en = 1'b0; ieu_memtoreg = 1'b0;
  endtask

  initial begin
    int st, r0, w0;
    brq_rst = 1'b1;
    ieu_mem_ren = 0; ieu_mem_wen = 0; ieu_memtoreg = 0; ieu_regfile_en = 0; ieu_func3 = 0;
    ieu_addr_dst = 0; ieu_mem_addr = 0; ieu_store_data = 0; ieu_alu_result_dealy = 0;
    mem_word = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_we = 0;
    lr_addr = 0; lr_be = 0; lr_wdata = 0;
    repeat (2) @(posedge brq_clk);
    #1 brq_rst = 1'b0;
    @(negedge brq_clk);
    chk("rst_req", 32'(ldst_req), 0);
    chk("rst_we", 32'(ldst_we), 0);
    chk("rst_addr", ldst_addr, 0);
    chk("rst_be", 32'(ldst_be), 0);
    chk("rst_wdata", ldst_wdata, 0);
    chk("rst_stall", 32'(ldst_stall), 0);
    chk("rst_rfen", 32'(ldst_regfile_en), 0);
    chk("rst_memtoreg", 32'(ldst_memtoreg), 0);
    chk("rst_addr_dst", 32'(ldst_addr_dst), 0);
    chk("rst_mem_result", ldst_mem_result, 0);
    chk("rst_alu_result", ldst_alu_result, 0);
    chk("rst_misaligned", 32'(ldst_misaligned), 0);

    // ADD flowing through
    run_instr(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1, 0, 32'h0, 0, 0, st);
    chk("add_stall", 32'(st), 0);
    bubble();
    @(negedge brq_clk);
    chk("add_alu", ldst_alu_result, 32'h1234);
    chk("add_rfen", 32'(ldst_regfile_en), 1);
    chk("add_rd", 32'(ldst_addr_dst), 5);

    // SB to byte lane 3, regfile_en set on the store must not write back
    r0 = req_cycles;
    run_instr(0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 5'd3, 1, 0, 32'h0, 0, 0, st);
    chk("sb_stall", 32'(st), 2);
    chk("sb_addr", lr_addr, 32'h1000);
    chk("sb_be", 32'(lr_be), 32'h8);
    chk("sb_wdata", lr_wdata, 32'hA5A5_A5A5);
    chk("sb_req_cycles", 32'(req_cycles - r0), 1);
    chk("sb_rfen", 32'(ldst_regfile_en), 0);

    // LB / LBU / LH / LHU back to back
    run_instr(1, 0, 3'b000, 32'h2002, 32'h0, 32'h0, 5'd10, 1, 1, 32'h0080_0000, 0, 0, st);
    chk("lb_stall", 32'(st), 3);
    chk("lb_result", ldst_mem_result, 32'hFFFF_FF80);
    chk("lb_rfen", 32'(ldst_regfile_en), 1);
    run_instr(1, 0, 3'b100, 32'h2002, 32'h0, 32'h0, 5'd11, 1, 1, 32'h0080_0000, 0, 0, st);
    chk("lbu_stall", 32'(st), 3);
    chk("lbu_result", ldst_mem_result, 32'h0000_0080);
    run_instr(1, 0, 3'b001, 32'h2002, 32'h0, 32'h0, 5'd12, 1, 1, 32'h8001_1234, 0, 1, st);
    chk("lh_stall", 32'(st), 4);
    chk("lh_result", ldst_mem_result, 32'hFFFF_8001);
    run_instr(1, 0, 3'b101, 32'h2002, 32'h0, 32'h0, 5'd12, 1, 0, 32'h8001_1234, 0, 0, st);
    chk("lhu_result", ldst_mem_result, 32'h0000_8001);

    // SH to upper half, SW with delayed grant
    run_instr(0, 1, 3'b001, 32'h2006, 32'h1234_BEEF, 32'h0, 5'd0, 0, 0, 32'h0, 1, 0, st);
    chk("sh_stall", 32'(st), 3);
    chk("sh_addr", lr_addr, 32'h2004);
    chk("sh_be", 32'(lr_be), 32'hC);
    chk("sh_wdata", lr_wdata, 32'hBEEF_BEEF);
    run_instr(0, 1, 3'b010, 32'h2008, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0, 32'h0, 2, 0, st);
    chk("sw_stall", 32'(st), 4);
    chk("sw_be", 32'(lr_be), 32'hF);
    chk("sw_wdata", lr_wdata, 32'hDEAD_BEEF);

    // LW with grant delayed three cycles
    r0 = req_cycles; w0 = wb_pulses;
    run_instr(1, 0, 3'b010, 32'h4000, 32'h0, 32'h0, 5'd14, 1, 1, 32'h1234_5678, 3, 0, st);
    chk("lw_wait_stall", 32'(st), 6);
    chk("lw_wait_req_cycles", 32'(req_cycles - r0), 4);
    chk("lw_wait_result", ldst_mem_result, 32'h1234_5678);
    bubble();
    repeat (3) @(negedge brq_clk);
    chk("lw_wait_rfen_pulses", 32'(wb_pulses - w0), 1);

    // LW to a half-aligned address
    r0 = req_cycles;
    run_instr(1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 5'd13, 1, 1, 32'hAABB_CCDD, 0, 0, st);
`ifdef LDST_MISALIGN_TRAP_EN
    chk("mis_stall", 32'(st), 0);
    bubble();
    @(negedge brq_clk);
    chk("mis_pulse", 32'(ldst_misaligned), 1);
    chk("mis_rfen", 32'(ldst_regfile_en), 0);
    @(negedge brq_clk);
    chk("mis_pulse_end", 32'(ldst_misaligned), 0);
    chk("mis_no_req", 32'(req_cycles - r0), 0);
`else
    chk("mis_stall", 32'(st), 3);
    chk("mis_addr", lr_addr, 32'h3000);
    chk("mis_be", 32'(lr_be), 32'hF);
    chk("mis_result", ldst_mem_result, 32'h0000_AABB);
    chk("mis_flag", 32'(ldst_misaligned), 0);
    chk("mis_req_cycles", 32'(req_cycles - r0), 1);
`endif

    // Reset while waiting for load data; the late rvalid must be ignored
    @(posedge brq_clk); #1;
    ieu_mem_ren = 1; ieu_mem_wen = 0; ieu_func3 = 3'b010; ieu_mem_addr = 32'h5000;
    ieu_addr_dst = 5'd15; ieu_regfile_en = 1; ieu_memtoreg = 1;
    mem_word = 32'hFFFF_FFFF; gnt_wait = 0; rv_wait = 4;
    exp_addr = 32'h5000; exp_be = 4'hF; exp_wdata = m_wdata(3'b010, ieu_store_data); exp_we = 0;
    @(negedge brq_clk);
    @(negedge brq_clk);
    @(posedge brq_clk); #1;
    brq_rst = 1'b1;
    ieu_mem_ren = 0; ieu_regfile_en = 0; ieu_memtoreg = 0;
    @(posedge brq_clk); #1;
    brq_rst = 1'b0;
    w0 = wb_pulses; r0 = req_cycles;
    repeat (6) @(negedge brq_clk);
    chk("rst_mid_stall", 32'(ldst_stall), 0);
    chk("rst_mid_mem_result", ldst_mem_result, 0);
    chk("rst_mid_wb", 32'(wb_pulses - w0), 0);
    chk("rst_mid_req", 32'(req_cycles - r0), 0);

    run_instr(0, 0, 3'b000, 32'h0, 32'h0, 32'h0000_0077, 5'd6, 1, 0, 32'h0, 0, 0, st);
    bubble();
    @(negedge brq_clk);
    chk("post_rst_alu", ldst_alu_result, 32'h0000_0077);

    bubble();
    repeat (3) @(negedge brq_clk);
    chk("wb_drain", 32'(wbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldst_unit.md
# ldst_unit

Load/store stage of Buraq-Mini-RV32IM, placed between the execute stage and write-back. It takes the registered memory address, store data, func3 and control from execute, and runs the data-memory request/grant/rvalid handshake. It formats byte/halfword/word data in both directions and stalls the pipeline until each access completes. Non-memory instructions pass through to write-back in one cycle.

## Interface
Parameters:
- DataWidth, 32, data/address width
- RegAddrWidth, 5, register index width

Ports (one clock; reset is synchronous and active-high):
- brq_clk  in  1  clock
- brq_rst  in  1  synchronous active-high reset
- ieu_mem_ren  in  1  load request from execute
- ieu_mem_wen  in  1  store request from execute
- ieu_memtoreg  in  1  write-back selects memory data
- ieu_regfile_en  in  1  instruction writes rd
- ieu_func3  in  3  access size/sign
- ieu_addr_dst  in  RegAddrWidth  rd index
- ieu_mem_addr  in  DataWidth  byte address
- ieu_store_data  in  DataWidth  store data, LSB-aligned
- ieu_alu_result_dealy  in  DataWidth  ALU result for non-load instructions
- dmem_gnt  in  1  memory accepted request
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DataWidth  load word
- ldst_req  out  1  request to memory
- ldst_we  out  1  1 = write
- ldst_addr  out  DataWidth  word-aligned address ({addr[31:2],2'b00})
- ldst_be  out  4  byte enables
- ldst_wdata  out  DataWidth  lane-replicated store data
- ldst_stall  out  1  hold upstream stages
- ldst_regfile_en  out  1  write-back enable
- ldst_memtoreg  out  1  registered memtoreg
- ldst_addr_dst  out  RegAddrWidth  rd to write-back
- ldst_mem_result  out  DataWidth  formatted load data
- ldst_alu_result  out  DataWidth  registered ALU result
- ldst_misaligned  out  1  misalignment pulse (tied 0 when feature is compiled out)

## Operation
- FSM states: IDLE, REQ, WAIT.
- A register `done` marks a just-completed access.
- mem_access = ieu_mem_ren | ieu_mem_wen.
- IDLE, mem_access, !done:
  - Capture addr[1:0], func3, rd, regfile_en, memtoreg, we.
  - Drive ldst_addr, ldst_be and ldst_wdata into registers.
  - Go to REQ.
- REQ: ldst_req=1. On dmem_gnt:
  - Store: go to IDLE with done=1.
  - Load: go to WAIT.
- WAIT: on dmem_rvalid:
  - Register formatted data into ldst_mem_result.
  - Assert ldst_regfile_en with the captured enable.
  - Go to IDLE with done=1.
- done clears on the next cycle. In IDLE with done=1, the held instruction is treated as completed and is not re-issued.
- ldst_stall = (state != IDLE) | (mem_access & !done). This is combinational.
- Non-memory path: in IDLE with !mem_access, register ieu_regfile_en, addr_dst, memtoreg and alu_result each cycle.
- While stalled, ldst_regfile_en=0 (bubble). The exception is the completion cycle of a load.
- A store completion gives ldst_regfile_en=0.
- Byte enables by func3[1:0]:
  - 00 → 4'b0001 << off
  - 01 → 4'b0011 << off
  - 10 → 4'b1111
  - Result is truncated to 4 bits.
- Store wdata by func3[1:0]:
  - SB: byte replicated ×4.
  - SH: half replicated ×2.
  - SW: unchanged.
- Load format:
  - Shift rdata right by 8·off.
  - func3 000 LB / 001 LH: sign-extend.
  - func3 100 LBU / 101 LHU: zero-extend.
  - func3 010 LW: unchanged.
- dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.

## Timing
- Reset values: state IDLE, done=0. Every output is 0, including ldst_req, ldst_be, ldst_wdata and ldst_addr.
- Non-memory latency: 1 cycle.
- Load, gnt in the first REQ cycle and rvalid one cycle later:
  - accept at cycle 0, REQ at 1, WAIT at 2.
  - Result and ldst_regfile_en visible at cycle 3.
  - ldst_stall high in cycles 0–2, low in cycle 3.
- Store, gnt in the first REQ cycle: stall high in cycles 0–1, low in cycle 2.
- Grant wait: ldst_req, ldst_addr, ldst_be, ldst_wdata and ldst_we are held stable until dmem_gnt.
- After the grant cycle, ldst_req deasserts on the next edge.
- Reset mid-access: FSM goes to IDLE at that edge and the outstanding transaction is abandoned. A later rvalid is ignored.
- Back-to-back memory instructions: the second is accepted in the cycle after done clears.

## Configuration
- LDST_MISALIGN_TRAP_EN defined:
  - Half-word accesses with addr[0]=1 are not issued.
  - Word accesses with addr[1:0]≠0 are not issued.
  - Instead ldst_misaligned=1 for one cycle (registered, next edge) and ldst_regfile_en=0.
  - ldst_stall is low; the instruction completes in IDLE.
- Undefined:
  - The access is issued with truncated byte enables.
  - Missing load bytes read as 0 before extension.
  - ldst_misaligned is tied 0.

## Test plan
- Reset held 2 cycles, then released → all outputs 0, state IDLE, no ldst_req.
- SB data 0x000000A5 to 0x1003, gnt immediate → ldst_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5; stall low in cycle 2.
- LB from 0x2002, rdata 0x0080_0000, rvalid one cycle after gnt → ldst_mem_result 0xFFFFFF80 at cycle 3. LBU from the same address gives 0x00000080.
- LW with gnt delayed 3 cycles → req/addr/be stable across the wait; stall high until result; ldst_regfile_en pulses exactly once.
- ADD result 0x1234 flowing through IDLE → ldst_alu_result 0x1234 and ldst_regfile_en=1 one cycle later, no stall.
- LW to 0x3002 → with LDST_MISALIGN_TRAP_EN: ldst_misaligned pulse, no ldst_req. Without it: be 4'b1111, normal load.
